// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyph table,
// decimal-point bit position and the all-segments-off pattern.
package seven_seg_pkg;

  localparam int DP_BIT = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low glyphs for hex digits 0..F.
  localparam logic [7:0] GLYPH_TABLE [16] = '{
    8'h11, 8'hD7, 8'h32, 8'h92, 8'hD4, 8'h98, 8'h18, 8'hD3,
    8'h10, 8'h90, 8'h50, 8'h1C, 8'h39, 8'h16, 8'h38, 8'h78
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble-to-segment decoder; a set dp bit pulls the
// decimal-point segment low (lit).
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] segments
);

  logic [7:0] glyph_s;

  // Table lookup plus optional decimal point.
  always_comb begin
    glyph_s = hex_to_seg(nibble);
    if (dp) begin
      segments = glyph_s & ~(8'h01 << DP_BIT);
    end else begin
      segments = glyph_s;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Self-timed multiplexed seven-segment driver: frame-aligned shadow capture,
// per-digit blanking/dp, PWM brightness and a dead cycle at each slot start.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter  int DIGITS       = 4,
  parameter  int REFRESH_LOG2 = 16,
  parameter  int BRIGHT_W     = 4,
  localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [4*DIGITS-1:0]   digitData,
  input  logic [DIGITS-1:0]     blankMask,
  input  logic [DIGITS-1:0]     dpMask,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  displayOn,
  output logic [DIGITS-1:0]     sevenSegmentEnable,
  output logic [7:0]            sevenSegmentData,
  output logic                  frameStrobe,
  output logic [IDX_W-1:0]      activeDigit
);

  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]        ONE_IDX   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [REFRESH_LOG2-1:0] ONE_SLOT  = {{(REFRESH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DIGITS-1:0]       ONE_HOT   = {{(DIGITS-1){1'b0}}, 1'b1};

  if (DIGITS < 2 || DIGITS > 8) begin : g_badDigits
    $error("seven_seg_scanner: DIGITS must be in 2..8");
  end
  if (REFRESH_LOG2 < BRIGHT_W || REFRESH_LOG2 < 2) begin : g_badRefresh
    $error("seven_seg_scanner: REFRESH_LOG2 must be >= BRIGHT_W and >= 2");
  end

  logic [REFRESH_LOG2-1:0] slotCnt_r;
  logic [IDX_W-1:0]        digitIdx_r;
  logic [3:0]              shadowNib_r [DIGITS];
  logic [DIGITS-1:0]       shadowBlank_r;
  logic [DIGITS-1:0]       shadowDp_r;
  logic [BRIGHT_W-1:0]     shadowBright_r;

  logic                    slotWrap_s;
  logic                    frameStart_s;
  logic [BRIGHT_W-1:0]     phase_s;
  logic                    lit_s;
  logic [3:0]              curNib_s;
  logic                    curDp_s;
  logic [7:0]              segments_s;
  logic [DIGITS-1:0]       enableNext_s;

  // Slot counter and digit index; the index wraps explicitly so DIGITS need not be a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slotCnt_r  <= '0;
      digitIdx_r <= '0;
    end else begin
      slotCnt_r <= slotCnt_r + ONE_SLOT;
      if (slotWrap_s) begin
        if (digitIdx_r == LAST_IDX) begin
          digitIdx_r <= '0;
        end else begin
          digitIdx_r <= digitIdx_r + ONE_IDX;
        end
      end
    end
  end

  // Shadow capture at frame start so a frame never mixes old and new values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DIGITS; i++) begin
        shadowNib_r[i] <= 4'h0;
      end
      shadowBlank_r  <= '0;
      shadowDp_r     <= '0;
      shadowBright_r <= '0;
    end else if (frameStart_s) begin
      for (int i = 0; i < DIGITS; i++) begin
        shadowNib_r[i] <= digitData[4*i +: 4];
      end
      shadowBlank_r  <= blankMask;
      shadowDp_r     <= dpMask;
      shadowBright_r <= brightness;
    end
  end

  // Scan decode: lit window, PWM phase and next anode pattern.
  always_comb begin
    slotWrap_s   = &slotCnt_r;
    frameStart_s = (slotCnt_r == '0) && (digitIdx_r == '0);
    phase_s      = slotCnt_r[REFRESH_LOG2-1 -: BRIGHT_W];
    curNib_s     = shadowNib_r[digitIdx_r];
    curDp_s      = shadowDp_r[digitIdx_r];
    // Slot position 0 is the anti-ghost dead cycle.
    lit_s        = (slotCnt_r != '0) && displayOn && !shadowBlank_r[digitIdx_r] &&
                   ((&shadowBright_r) || (phase_s < shadowBright_r));
    if (lit_s) begin
      enableNext_s = ~(ONE_HOT << digitIdx_r);
    end else begin
      enableNext_s = '1;
    end
  end

  seven_seg_decoder u_decoder (
    .nibble   (curNib_s),
    .dp       (curDp_s),
    .segments (segments_s)
  );

  // Registered pin drivers, one cycle behind the scan counters.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sevenSegmentEnable <= '1;
      sevenSegmentData   <= SEG_OFF;
      frameStrobe        <= 1'b0;
      activeDigit        <= '0;
    end else begin
      sevenSegmentEnable <= enableNext_s;
      sevenSegmentData   <= segments_s;
      frameStrobe        <= frameStart_s;
      activeDigit        <= digitIdx_r;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised bench for seven_seg_scanner against a cycle-count reference model
// (4-digit and 3-digit instances).
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, rstB;
  logic [15:0] digitData;
  logic [3:0]  blankMask, dpMask;
  logic [1:0]  brightness;
  logic        displayOn;

  logic [3:0]  enA;
  logic [7:0]  segA;
  logic        stbA;
  logic [1:0]  actA;
  logic [2:0]  enB;
  logic [7:0]  segB;
  logic        stbB;
  logic [1:0]  actB;

  seven_seg_scanner #(.DIGITS(4), .REFRESH_LOG2(4), .BRIGHT_W(2)) dutA (
    .clk(clk), .rstN(rstA), .digitData(digitData), .blankMask(blankMask),
    .dpMask(dpMask), .brightness(brightness), .displayOn(displayOn),
    .sevenSegmentEnable(enA), .sevenSegmentData(segA),
    .frameStrobe(stbA), .activeDigit(actA)
  );

  seven_seg_scanner #(.DIGITS(3), .REFRESH_LOG2(2), .BRIGHT_W(2)) dutB (
    .clk(clk), .rstN(rstB), .digitData(digitData[11:0]), .blankMask(blankMask[2:0]),
    .dpMask(dpMask[2:0]), .brightness(brightness), .displayOn(displayOn),
    .sevenSegmentEnable(enB), .sevenSegmentData(segB),
    .frameStrobe(stbB), .activeDigit(actB)
  );

  int nChecks = 0;
  int nFails  = 0;
  int t;

  logic [7:0] glyphRef [16] = '{
    8'h11, 8'hD7, 8'h32, 8'h92, 8'hD4, 8'h98, 8'h18, 8'hD3,
    8'h10, 8'h90, 8'h50, 8'h1C, 8'h39, 8'h16, 8'h38, 8'h78
  };

  // Model shadow: what the display shows during the current frame.
  logic [3:0] shNib [4];
  logic [3:0] shBlank, shDp;
  logic [1:0] shBright;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 4; i++) shNib[i] = 4'h0;
    shBlank  = 4'h0;
    shDp     = 4'h0;
    shBright = 2'd0;
    t        = 0;
  endtask

  // One clock of cycle t: predict from elapsed-cycle arithmetic, then compare the pins.
  task automatic stepCheck(input int digits, input int rlog2, input bit isB);
    int slotLen, slotPos, d, phase;
    bit lit, fs;
    logic [31:0] allOff, expEn;
    logic [7:0]  expSeg;
    slotLen = 1 << rlog2;
    slotPos = t % slotLen;
    d       = (t / slotLen) % digits;
    phase   = (slotPos * 4) / slotLen;
    fs      = (t % (slotLen * digits)) == 0;
    lit     = (slotPos != 0) && (displayOn == 1'b1) && (shBlank[d] == 1'b0) &&
              ((shBright == 2'd3) || (phase < int'(shBright)));
    allOff  = (32'd1 << digits) - 32'd1;
    expEn   = lit ? (allOff & ~(32'd1 << d)) : allOff;
    expSeg  = glyphRef[shNib[d]];
    if (shDp[d]) expSeg = expSeg & 8'hEF;
    @(posedge clk);
    #1;
    if (isB) begin
      checkValue("B.enable", 32'(enB), expEn);
      if (lit) checkValue("B.segments", 32'(segB), 32'(expSeg));
      checkValue("B.strobe", 32'(stbB), 32'(fs));
      checkValue("B.digit", 32'(actB), 32'(d));
    end else begin
      checkValue("A.enable", 32'(enA), expEn);
      if (lit) checkValue("A.segments", 32'(segA), 32'(expSeg));
      checkValue("A.strobe", 32'(stbA), 32'(fs));
      checkValue("A.digit", 32'(actA), 32'(d));
    end
    if (fs) begin
      for (int i = 0; i < 4; i++) shNib[i] = digitData[4*i +: 4];
      shBlank  = blankMask;
      shDp     = dpMask;
      shBright = brightness;
    end
    t++;
  endtask

  task automatic randomPoke();
    case ($urandom_range(0, 5))
      0: digitData  = 16'($urandom);
      1: blankMask  = 4'($urandom);
      2: dpMask     = 4'($urandom);
      3: brightness = 2'($urandom);
      4: displayOn  = ($urandom_range(0, 3) != 0);
      default: digitData = 16'($urandom);
    endcase
  endtask

  task automatic checkResetA();
    checkValue("A.rst.enable", 32'(enA), 32'hF);
    checkValue("A.rst.segments", 32'(segA), 32'hFF);
    checkValue("A.rst.strobe", 32'(stbA), 32'h0);
    checkValue("A.rst.digit", 32'(actA), 32'h0);
  endtask

  task automatic checkResetB();
    checkValue("B.rst.enable", 32'(enB), 32'h7);
    checkValue("B.rst.segments", 32'(segB), 32'hFF);
    checkValue("B.rst.strobe", 32'(stbB), 32'h0);
    checkValue("B.rst.digit", 32'(actB), 32'h0);
  endtask

  initial begin
    rstA       = 1'b0;
    rstB       = 1'b0;
    digitData  = 16'h3210;
    blankMask  = 4'h0;
    dpMask     = 4'h0;
    brightness = 2'd3;
    displayOn  = 1'b1;
    clearModel();

    repeat (3) @(negedge clk);
    checkResetA();
    checkResetB();

    // 4-digit instance: directed frames, then random traffic.
    @(negedge clk);
    rstA = 1'b1;
    clearModel();
    for (int c = 0; c < 1600; c++) begin
      if (t == 64)       brightness = 2'd1;
      if (t == 128)      brightness = 2'd0;
      if (t == 192)      brightness = 2'd3;
      if (t == 192 + 30) digitData  = 16'hFEDC;
      if (t == 320) begin
        digitData = 16'h8888;
        blankMask = 4'b0100;
        dpMask    = 4'b0001;
      end
      if (t == 384 + 21) displayOn = 1'b0;
      if (t == 384 + 40) displayOn = 1'b1;
      if (t >= 448 && $urandom_range(0, 11) == 0) randomPoke();
      stepCheck(4, 4, 1'b0);
    end

    // 3-digit instance with short slots.
    @(negedge clk);
    digitData  = 16'($urandom);
    blankMask  = 4'h0;
    dpMask     = 4'($urandom);
    brightness = 2'd3;
    displayOn  = 1'b1;
    rstB = 1'b1;
    clearModel();
    for (int c = 0; c < 400; c++) begin
      if (t >= 24 && $urandom_range(0, 5) == 0) randomPoke();
      stepCheck(3, 2, 1'b1);
    end

    // Mid-frame asynchronous reset: outputs must clear before any clock edge.
    while (actB == 2'd0) stepCheck(3, 2, 1'b1);
    #2;
    rstA = 1'b0;
    rstB = 1'b0;
    #1;
    checkResetA();
    checkResetB();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
